// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the execution sequencer: FSM states, ARM condition
// codes and NZCV bit positions.
package core_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMulWait,
    StWb
  } state_e;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'hA;
  localparam logic [3:0] CondLt = 4'hB;
  localparam logic [3:0] CondGt = 4'hC;
  localparam logic [3:0] CondLe = 4'hD;
  localparam logic [3:0] CondAl = 4'hE;
  localparam logic [3:0] CondNv = 4'hF;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and instruction memory.
interface exec_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/exec_sequencer_cond_eval.sv
// Combinational ARM condition-field evaluator against an NZCV flag vector.
module cond_eval
  import core_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FlagN];
  assign z = flags_i[FlagZ];
  assign c = flags_i[FlagC];
  assign v = flags_i[FlagV];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      CondEq:  pass_o = z;
      CondNe:  pass_o = ~z;
      CondCs:  pass_o = c;
      CondCc:  pass_o = ~c;
      CondMi:  pass_o = n;
      CondPl:  pass_o = ~n;
      CondVs:  pass_o = v;
      CondVc:  pass_o = ~v;
      CondHi:  pass_o = c & ~z;
      CondLs:  pass_o = ~c | z;
      CondGe:  pass_o = (n == v);
      CondLt:  pass_o = (n != v);
      CondGt:  pass_o = ~z & (n == v);
      CondLe:  pass_o = z | (n != v);
      CondAl:  pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode window, condition check, multiply
// stall and write-back strobes. All outputs are registered.
module exec_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  exec_sequencer_if.master       imem,
  input  logic                   start_i,
  input  logic                   halt_i,
  output logic [31:0]            instr_o,
  output logic                   dec_active_o,
  input  logic                   dec_reg_w_i,
  input  logic                   dec_mult_hot_i,
  input  logic                   dec_s_on_i,
  input  logic [3:0]             alu_flags_i,
  output logic [3:0]             flags_o,
  output logic                   cond_pass_o,
  output logic                   reg_we_o,
  output logic                   pc_we_o,
  output logic                   busy_o,
  output logic [31:0]            retired_o
);

  localparam logic [3:0] CntLoad = 4'(MULT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] instr_q, retired_q;
  logic [3:0]  flags_q, cnt_q;
  logic        cond_pass_q, reg_w_q, s_on_q;
  logic        imem_req_q, dec_active_q, busy_q, reg_we_q, pc_we_q;
  logic        reg_w_d, pass;

  cond_eval u_cond_eval (
    .cond_i  (instr_q[31:28]),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StFetch;
      StFetch:   if (imem.imem_ack) state_d = StDecode;
      StDecode:  state_d = StExec;
      StExec:    state_d = (cond_pass_q && dec_mult_hot_i) ? StMulWait : StWb;
      StMulWait: if (cnt_q == 4'd0) state_d = StWb;
      StWb:      state_d = halt_i ? StIdle : StFetch;
      default:   state_d = StIdle;
    endcase
  end

  // The write strobe for the EXEC->WB edge must see the decoder value sampled on that edge.
  assign reg_w_d = (state_q == StExec) ? dec_reg_w_i : reg_w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      flags_q      <= '0;
      retired_q    <= '0;
      cnt_q        <= '0;
      cond_pass_q  <= 1'b0;
      reg_w_q      <= 1'b0;
      s_on_q       <= 1'b0;
      imem_req_q   <= 1'b0;
      dec_active_q <= 1'b0;
      busy_q       <= 1'b0;
      reg_we_q     <= 1'b0;
      pc_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= (state_d == StFetch);
      dec_active_q <= (state_d inside {StDecode, StExec, StMulWait});
      busy_q       <= (state_d != StIdle);
      pc_we_q      <= (state_d == StWb);
      reg_we_q     <= (state_d == StWb) && cond_pass_q && reg_w_d;

      if (state_q == StFetch && imem.imem_ack) instr_q <= imem.imem_rdata;
      if (state_q == StDecode) cond_pass_q <= pass;
      if (state_q == StExec) begin
        reg_w_q <= dec_reg_w_i;
        s_on_q  <= dec_s_on_i;
        if (cond_pass_q && dec_mult_hot_i) cnt_q <= CntLoad;
      end
      if (state_q == StMulWait && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (state_q == StWb && cond_pass_q) begin
        retired_q <= retired_q + 32'd1;
        if (s_on_q) flags_q <= alu_flags_i;
      end
    end
  end

  assign imem.imem_req = imem_req_q;
  assign instr_o       = instr_q;
  assign dec_active_o  = dec_active_q;
  assign flags_o       = flags_q;
  assign cond_pass_o   = cond_pass_q;
  assign reg_we_o      = reg_we_q;
  assign pc_we_o       = pc_we_q;
  assign busy_o        = busy_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised scoreboard bench for exec_sequencer with a per-instruction reference model.
module tb_exec_sequencer;

  localparam int unsigned MC = 4;

  typedef struct {
    logic [31:0] instr;
    int unsigned wb_cyc;
    int unsigned active_len;
    logic        pass;
    logic        reg_we;
    logic [3:0]  flags;
    logic [31:0] retired;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0, halt_i = 1'b0;
  logic        dec_reg_w_i = 1'b0, dec_mult_hot_i = 1'b0, dec_s_on_i = 1'b0;
  logic [3:0]  alu_flags_i = 4'h0;
  logic [31:0] instr_o, retired_o;
  logic [3:0]  flags_o;
  logic        dec_active_o, cond_pass_o, reg_we_o, pc_we_o, busy_o;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [3:0]  m_flags = 4'h0;
  logic [31:0] m_retired = 32'h0;

  exec_sequencer_if bus ();

  exec_sequencer #(.MULT_CYCLES(MC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .start_i        (start_i),
    .halt_i         (halt_i),
    .instr_o        (instr_o),
    .dec_active_o   (dec_active_o),
    .dec_reg_w_i    (dec_reg_w_i),
    .dec_mult_hot_i (dec_mult_hot_i),
    .dec_s_on_i     (dec_s_on_i),
    .alu_flags_i    (alu_flags_i),
    .flags_o        (flags_o),
    .cond_pass_o    (cond_pass_o),
    .reg_we_o       (reg_we_o),
    .pc_we_o        (pc_we_o),
    .busy_o         (busy_o),
    .retired_o      (retired_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference meaning of the ARM condition field, written straight from the condition table.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_req(output logic ok);
    int unsigned w = 0;
    while (bus.imem_req !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    ok = (bus.imem_req === 1'b1);
    if (!ok) check("imem_req_timeout", {31'b0, bus.imem_req}, 32'h1);
  endtask

  task automatic issue(input logic [31:0] ins, input logic rw, input logic mh, input logic so,
                       input logic [3:0] af, input int unsigned dly, input logic hlt);
    logic        ok, p;
    exp_t        e;
    int unsigned w;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < int'(dly); i++) begin
      @(posedge clk); #1;
      check("imem_req_held", {31'b0, bus.imem_req}, 32'h1);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = ins;
    dec_reg_w_i    = rw;
    dec_mult_hot_i = mh;
    dec_s_on_i     = so;
    alu_flags_i    = af;
    p = cond_ok(ins[31:28], m_flags);
    e.instr      = ins;
    e.pass       = p;
    e.wb_cyc     = cyc + 3 + ((p && mh) ? MC : 0);
    e.active_len = 2 + ((p && mh) ? MC : 0);
    e.reg_we     = p && rw;
    if (p && so) m_flags = af;
    if (p) m_retired = m_retired + 32'd1;
    e.flags   = m_flags;
    e.retired = m_retired;
    q.push_back(e);
    if (hlt) begin
      halt_i  = 1'b1;
      start_i = 1'b1;
    end
    @(posedge clk); #1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    if (hlt) begin
      w = 0;
      while (pc_we_o !== 1'b1 && w < 60) begin
        @(posedge clk); #1; w++;
      end
      check("halt_wb_seen", {31'b0, pc_we_o}, 32'h1);
      @(posedge clk); #1;
      halt_i  = 1'b0;
      start_i = 1'b0;
      check("halt_busy", {31'b0, busy_o}, 32'h0);
      check("halt_req", {31'b0, bus.imem_req}, 32'h0);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
  endtask

  // Monitor: pops one expectation per write-back pulse.
  exp_t        cur;
  logic        pend = 1'b0;
  int unsigned active_run = 0;
  always @(negedge clk) begin
    if (pend) begin
      check("flags_after_wb", {28'b0, flags_o}, {28'b0, cur.flags});
      check("retired_after_wb", retired_o, cur.retired);
      pend = 1'b0;
    end
    if (dec_active_o === 1'b1) active_run++;
    if (reg_we_o === 1'b1 && pc_we_o !== 1'b1) check("reg_we_outside_wb", 32'h1, 32'h0);
    if (pc_we_o === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_wb", 32'h1, 32'h0);
      end else begin
        cur = q.pop_front();
        check("wb_cycle", cyc, cur.wb_cyc);
        check("reg_we", {31'b0, reg_we_o}, {31'b0, cur.reg_we});
        check("cond_pass", {31'b0, cond_pass_o}, {31'b0, cur.pass});
        check("instr", instr_o, cur.instr);
        check("dec_active_len", active_run, cur.active_len);
        check("busy_in_wb", {31'b0, busy_o}, 32'h1);
        pend = 1'b1;
      end
      active_run = 0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'b0, bus.imem_req, dec_active_o, cond_pass_o, reg_we_o, pc_we_o,
                           busy_o}, 32'h0);
    check({tag, "_instr"}, instr_o, 32'h0);
    check({tag, "_flags"}, {28'b0, flags_o}, 32'h0);
    check({tag, "_retired"}, retired_o, 32'h0);
  endtask

  initial begin
    int unsigned w;
    logic        ok;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", {31'b0, busy_o}, 32'h0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;

    issue(32'hE0810002, 1, 0, 0, 4'h0, 0, 0);  // ADD AL
    issue(32'hE0910002, 1, 0, 1, 4'h4, 0, 0);  // sets Z
    issue(32'h10810002, 1, 0, 0, 4'h0, 0, 0);  // NE fails
    issue(32'hE0000091, 1, 1, 0, 4'h0, 0, 0);  // multiply
    issue(32'hE0910002, 1, 0, 1, 4'h9, 0, 0);  // flags = 1001
    issue(32'hA0810002, 1, 0, 0, 4'h0, 0, 0);  // GE passes
    issue(32'hB0810002, 1, 0, 0, 4'h0, 0, 0);  // LT fails
    issue(32'hE0810002, 1, 0, 0, 4'h0, 3, 0);  // delayed ack
    issue(32'hF0000091, 1, 1, 1, 4'hF, 1, 0);  // NV multiply never stalls
    issue(32'hE0810002, 1, 0, 0, 4'h0, 0, 1);  // halt with start
    for (int i = 0; i < 60; i++) begin
      logic [31:0] r;
      r = $urandom;
      issue({r[31:28], r[27:0]}, r[0], ($urandom_range(0, 3) == 0), r[1], r[5:2],
            $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    w = 0;
    while ((q.size() != 0 || pend) && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("queue_drained", q.size(), 32'h0);

    // Reset during the multiply stall.
    wait_req(ok);
    if (ok) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hE0000091;
      dec_mult_hot_i = 1'b1;
      dec_reg_w_i    = 1'b1;
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("mulwait_active", {31'b0, dec_active_o}, 32'h1);
      rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      @(posedge clk); #1;
      check("reset_no_strobe", {30'b0, reg_we_o, pc_we_o}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_idle", {30'b0, busy_o, bus.imem_req}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control FSM that sequences one instruction at a time through the core: fetches from instruction memory, latches the instruction for the decoder, gates the decoder's activity window, evaluates the ARM condition field against the architectural NZCV flags, stalls for the multiplier, and issues the register-file, PC and flag write strobes. It sits between instruction memory, the decoder and the ALU/multiplier datapath, and is the only block that drives the decoder's `isactive`.

## Interface
- `MULT_CYCLES`, 4, EXEC-to-WB stall for multiply instructions, in cycles; legal range 1..15.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  leave IDLE and begin fetching.
- `halt`  in  1  return to IDLE after the current instruction retires.
- `imem_req`  out  1  fetch request, held until acknowledged.
- `imem_ack`  in  1  fetch data valid.
- `imem_rdata`  in  32  fetched instruction.
- `instr`  out  32  latched instruction register, feeds the decoder.
- `dec_active`  out  1  decoder enable.
- `dec_reg_w`, `dec_mult_hot`, `dec_S_on`  in  1 each  decoder outputs.
- `alu_flags`  in  4  NZCV produced by the datapath, order {N,Z,C,V}.
- `flags`  out  4  architectural NZCV register.
- `cond_pass`  out  1  registered condition result for `instr`.
- `reg_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC advance strobe.
- `busy`  out  1  high in every state except IDLE.
- `retired`  out  32  count of instructions whose condition passed.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MULWAIT, WB.
- IDLE: all strobes low. `start`=1 -> FETCH.
- FETCH: `imem_req`=1. On `imem_ack`=1, `instr`<=`imem_rdata` -> DECODE. Without an ack, stay in FETCH indefinitely. `halt` is ignored in this state.
- DECODE: `dec_active`=1. `cond_pass`<=cond_eval(`instr[31:28]`, `flags`) -> EXEC.
- EXEC: `dec_active`=1. Register `dec_reg_w`, `dec_mult_hot` and `dec_S_on` internally.
  - `cond_pass`=0 -> WB.
  - `dec_mult_hot`=1 -> MULWAIT; down-counter loaded with MULT_CYCLES-1.
  - Otherwise -> WB.
- MULWAIT: `dec_active` stays 1. Counter decrements each cycle; at count 0 -> WB.
- WB, single cycle:
  - `pc_we`=1 unconditionally.
  - `reg_we` = `cond_pass` & registered `reg_w`.
  - `flags`<=`alu_flags` if `cond_pass` & registered `S_on`.
  - `retired`++ if `cond_pass`; wraps 0xFFFFFFFF -> 0.
  - Next state: `halt`=1 -> IDLE, else FETCH.
- Condition codes:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 0xF (NV) 0.
- A condition-failed instruction still takes the full DECODE/EXEC/WB path and advances the PC. It never enters MULWAIT.

## Timing
- Reset (async assert, sync to `clk` on deassert): state IDLE. `instr`, `flags`, `retired`, counter = 0. All 1-bit outputs 0.
- Reset asserted mid-instruction aborts immediately. No write strobe may fire in the cycle reset is asserted.
- Latency, zero-wait fetch (ack in first FETCH cycle): non-multiply 4 cycles FETCH->WB; multiply 4+MULT_CYCLES.
- `reg_w`, `mult_hot` and `S_on` are sampled on the EXEC clock edge only.
- `reg_we` and `pc_we` are one-cycle pulses, asserted only in WB.
- `flags` update is visible to the DECODE of the next instruction. There is no hazard window.
- `start` and `halt` both high in WB: `halt` wins.

## Structure
- `core_pkg` holds:
  - state enum;
  - 4-bit condition-code constants;
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0).
- Sub-module `cond_eval`: purely combinational, (`cond[3:0]`, `flags[3:0]`) -> `pass`. Instantiated once.

## Test plan
- Reset then `start`, ack immediate, `imem_rdata`=0xE0810002 (ADD, AL), `dec_reg_w`=1 -> `reg_we` and `pc_we` pulse in cycle 4; `retired`=1; `flags` unchanged.
- `flags`=0b0100 (Z set), fetch 0x10810002 (NE ADD) -> `cond_pass`=0, `reg_we`=0, `pc_we`=1, `retired` unchanged.
- Multiply with `dec_mult_hot`=1, MULT_CYCLES=4 -> WB in cycle 8; `dec_active` high in cycles 2..7.
- `dec_S_on`=1, `alu_flags`=0b1001 -> `flags`=0b1001 after WB. A following GE instruction passes; an LT instruction fails.
- `imem_ack` delayed 3 cycles -> `imem_req` held high for 3 cycles; WB occurs 3 cycles later than in the zero-wait case.
- `rst_n` low during MULWAIT -> all outputs 0 in the same cycle; no `reg_we`; IDLE after release.
